uart_rx_buffer: RTL and testbench
=================================

# uart_rx_buffer

Receive-side elastic buffer directly downstream of the UART core. Pulls received bytes from the UART over the `rxDataReady`/`rxDataReq` handshake and stores them in a small FIFO. Presents them first-word-fall-through on a valid/ready port to the consumer (register bank or DMA). Drives `rxDataStall` so the UART can deassert flow control (`rts_n`) before the buffer fills.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥4.
- `STALL_LEVEL`, DEPTH-2: fill level at or above which `rxDataStall` asserts; 1..DEPTH.

Ports:
- `ck`  input  1  block clock; all logic on rising edge.
- `arst`  input  1  reset, asynchronous, active-high.
- `flush`  input  1  synchronous clear of FIFO and handshake FSM; driven by `taskStopRx`.
- `rxData`  input  8  received byte from the UART; valid while `rxDataReady`=1.
- `rxDataReady`  input  1  UART holds a byte.
- `rxDataReq`  output  1  one-cycle pull/acknowledge pulse to the UART.
- `rxDataStall`  output  1  buffer nearly full; UART stops accepting new frames.
- `outData`  output  8  head-of-FIFO byte.
- `outValid`  output  1  FIFO non-empty.
- `outReady`  input  1  consumer accepts `outData` this cycle.
- `level`  output  $clog2(DEPTH)+1  current number of stored bytes.

## Operation
- FSM states: IDLE, REQ, GAP.
  - IDLE: if `rxDataReady`=1 and `level`<DEPTH, go to REQ.
  - REQ, one cycle: `rxDataReq`=1. `rxData` is written to the FIFO at the end of this cycle. Next state is GAP.
  - GAP, one cycle: no request, so the UART has time to drop `rxDataReady`. Next state is IDLE.
- At most one transfer is in flight. The minimum spacing between `rxDataReq` pulses is 3 cycles.
- Full: no request is issued while `level`=DEPTH. The UART keeps its byte; its own overrun handling is out of scope here.
- Read: occurs when `outValid` and `outReady` are both 1. The read pointer advances and `outData` moves to the next entry in the same cycle.
- `level` update per cycle:
  - +1 on write only
  - −1 on read only
  - unchanged on simultaneous write and read
- A simultaneous write and read are always legal. The write is only possible with `level`<DEPTH, because the REQ decision was made on the previous level and reads only decrease it.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from `level`, not from pointer compare.
- `rxDataStall` = (`level` ≥ `STALL_LEVEL`), combinational from the registered `level`.
- Flush:
  - Clears the pointers and `level`, and forces the FSM to IDLE next cycle.
  - Flush has priority over a same-cycle write and read. If the FSM is in REQ during flush, the pulse is still output (the UART has released the byte) but the byte is discarded.
  - `outValid`=0 the cycle after flush.

## Timing
- Reset values: `rxDataReq`=0, `outValid`=0, `outData`=0x00 (memory contents are don't-care; `outData` is gated to 0 when empty), `level`=0, `rxDataStall`=0 (unless `STALL_LEVEL`=0, which is illegal), FSM=IDLE.
- Reset mid-transfer: all state clears immediately; a pending byte is lost.
- Latency:
  - `rxDataReady` rising in cycle N gives `rxDataReq`=1 in N+1.
  - With an empty FIFO, `outValid`=1 and `outData` valid in N+2.
- Sustained throughput: 1 byte per 3 cycles. This is far above any UART baud rate.
- Consumer side: `outData` and `outValid` are stable until accepted; `outReady` may be held high indefinitely.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_W`=8
  - `rx_buf_state_t` enum {IDLE, REQ, GAP}
- Sub-module `uart_sync_fifo`:
  - Parameterised width/depth register array with pointers and `level`.
  - Ports: `wrEn`, `wrData`, `rdEn`, `rdData`, `clr`.
  - Reusable by the TX side.
- The top level holds the handshake FSM, stall logic and output gating.

## Test plan
- Single byte: after reset, drive `rxData`=0xA5 with `rxDataReady`=1 in cycle 0 and drop it after the req.
  - Expect `rxDataReq` pulse in cycle 1 only.
  - Expect `outValid`=1 and `outData`=0xA5 in cycle 2, `level`=1.
  - `outReady`=1 then gives `level`=0 and `outValid`=0.
- Fill/stall with DEPTH=8 and `outReady`=0: push 0x00..0x07.
  - `rxDataStall` rises when `level` reaches 6.
  - With `rxDataReady` held for a 9th byte, no `rxDataReq` is issued while `level`=8.
  - One read gives exactly one req 1 cycle later.
- Wrap-around: stream 20 bytes (0x10..0x23) with `outReady`=1 throughout.
  - Output order is identical and `level` never exceeds 1.
  - Req spacing is exactly 3 cycles.
- Simultaneous: with `level`=4, a write and a read in the same cycle leave `level`=4.
  - The head advances, and the new byte appears after the existing 3.
- Flush in REQ: assert `flush` in the cycle `rxDataReq`=1 with `level`=3.
  - Next cycle `level`=0 and `outValid`=0; the byte is not stored; FSM is in IDLE.
- Async reset: assert `arst` mid-GAP with `level`=5.
  - All outputs go to reset values immediately; after release, normal single-byte behaviour resumes.

Source files
------------

// File: rtl/uart_pkg.sv
// Purpose : shared types and constants for the UART receive/transmit buffering blocks.
// Latency : n/a (types only).
// Backpressure : n/a.
//
// Contents: UART_DATA_W (byte width on the UART-facing buses) and the
// receive-buffer handshake state encoding.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } rx_buf_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Purpose : generic single-clock FIFO, register array with wrap-around pointers and a fill counter.
// Latency : write visible on rdData the cycle after wrEn; rdData is the head entry combinationally.
// Backpressure : none internally; caller must not write when level==DEPTH or read when level==0
//                (such requests are ignored).
//
// Ports:
//   ck, arst         clock, asynchronous active-high reset
//   clr              synchronous clear of pointers and level (wins over wrEn/rdEn)
//   wrEn, wrData     push one entry
//   rdEn, rdData     pop the head entry; rdData always shows the head (don't-care when empty)
//   level            number of stored entries, 0..DEPTH
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     ck,
  input  logic                     arst,
  input  logic                     clr,
  input  logic                     wrEn,
  input  logic [WIDTH-1:0]         wrData,
  input  logic                     rdEn,
  output logic [WIDTH-1:0]         rdData,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_wr, do_rd;

  // Full/empty come from the counter; pointers alone cannot tell them apart.
  assign do_wr = wrEn && (level_q != FULL_LVL) && !clr;
  assign do_rd = rdEn && (level_q != '0) && !clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap on natural overflow.
      if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; contents are only observable through a non-zero level.
  always_ff @(posedge ck) begin
    if (do_wr) mem_q[wr_ptr_q] <= wrData;
  end

  assign rdData = mem_q[rd_ptr_q];
  assign level  = level_q;

endmodule

// File: rtl/uart_rx_buffer.sv
// Purpose : receive elastic buffer between the UART core and its consumer, FWFT valid/ready output.
// Latency : rxDataReady in cycle N -> rxDataReq in N+1 -> outValid/outData in N+2 (empty FIFO).
// Backpressure : outReady low holds data; at level==DEPTH no pull is issued, rxDataStall at level>=STALL_LEVEL.
//
// Ports:
//   ck, arst                  clock, asynchronous active-high reset
//   flush                     synchronous clear of FIFO and handshake FSM
//   rxData, rxDataReady       byte offered by the UART
//   rxDataReq                 one-cycle pull/ack pulse back to the UART
//   rxDataStall               early flow-control warning to the UART
//   outData, outValid, outReady   consumer port (outData is 0 when empty)
//   level                     stored byte count
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int STALL_LEVEL = DEPTH - 2
) (
  input  logic                     ck,
  input  logic                     arst,
  input  logic                     flush,
  input  logic [UART_DATA_W-1:0]   rxData,
  input  logic                     rxDataReady,
  output logic                     rxDataReq,
  output logic                     rxDataStall,
  output logic [UART_DATA_W-1:0]   outData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] STALL_LVL = LW'(STALL_LEVEL);

  rx_buf_state_t          state_q, state_d;
  logic                   req_q, req_d;
  logic [LW-1:0]          fifo_level;
  logic [UART_DATA_W-1:0] fifo_rd_data;
  logic                   fifo_wr, fifo_rd;

  // Handshake FSM. The full check uses the current level: the write lands one
  // cycle later and reads in between can only lower the level, so it never overflows.
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rxDataReady && (fifo_level != FULL_LVL)) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end
      REQ:     state_d = GAP;  // GAP gives the UART a cycle to drop rxDataReady
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      req_d   = 1'b0;
    end
  end

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  // A flush during REQ still lets the pulse out (the UART has already let go
  // of the byte), but the byte itself is dropped.
  assign fifo_wr = (state_q == REQ) && !flush;
  assign fifo_rd = outValid && outReady;

  uart_sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ck     (ck),
    .arst   (arst),
    .clr    (flush),
    .wrEn   (fifo_wr),
    .wrData (rxData),
    .rdEn   (fifo_rd),
    .rdData (fifo_rd_data),
    .level  (fifo_level)
  );

  assign rxDataReq   = req_q;
  assign level       = fifo_level;
  assign outValid    = (fifo_level != '0);
  // Memory is unreset, so hide its contents while empty.
  assign outData     = outValid ? fifo_rd_data : '0;
  assign rxDataStall = (fifo_level >= STALL_LVL);

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;

  localparam int DEPTH = 8;
  localparam int STALL = 6;

  logic       ck = 1'b0;
  logic       arst = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] rxData = 8'h00;
  logic       rxDataReady = 1'b0;
  logic       rxDataReq;
  logic       rxDataStall;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady = 1'b0;
  logic [3:0] level;

  uart_rx_buffer #(.DEPTH(DEPTH), .STALL_LEVEL(STALL)) dut (
    .ck          (ck),
    .arst        (arst),
    .flush       (flush),
    .rxData      (rxData),
    .rxDataReady (rxDataReady),
    .rxDataReq   (rxDataReq),
    .rxDataStall (rxDataStall),
    .outData     (outData),
    .outValid    (outValid),
    .outReady    (outReady),
    .level       (level)
  );

  initial forever #5 ck = ~ck;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the stored bytes as a queue, plus the rules "a pull needs
  // the byte offered, room in the buffer, no flush, and 3 cycles since the last pull".
  logic [7:0] mq[$];
  logic [7:0] tx_q[$];   // bytes the UART still has to deliver
  bit         m_req    = 1'b0;
  int         cyc      = 0;
  int         last_req = -100;
  int         cur_lvl  = 0;
  bit         req_last = 1'b0;
  int         req_cnt  = 0;
  bit         wrap_mon = 1'b0;
  int         max_lvl  = 0;

  initial forever begin : model
    bit nreq;
    @(posedge ck or posedge arst);
    if (arst) begin
      mq.delete();
      m_req    = 1'b0;
      last_req = -100;
      cyc      = 0;
      cur_lvl  = 0;
    end else begin
      nreq = rxDataReady && (cur_lvl < DEPTH) && !flush && ((cyc + 1 - last_req) >= 3);
      if (flush) begin
        mq.delete();
        last_req = -100;
      end else if (m_req) begin
        mq.push_back(rxData);
      end
      if (nreq) last_req = cyc + 1;
      m_req = nreq;
      cyc++;
    end
  end

  // Monitor: compare every cycle, pop the scoreboard on each accepted output.
  initial forever begin : monitor
    int lvl;
    logic [7:0] exp_b;
    @(negedge ck);
    if (arst) begin
      req_last = 1'b0;
    end else begin
      lvl     = mq.size();
      cur_lvl = lvl;
      chk("req", int'(rxDataReq), int'(m_req));
      chk("level", int'(level), lvl);
      chk("out_valid", int'(outValid), int'(lvl != 0));
      chk("stall", int'(rxDataStall), int'(lvl >= STALL));
      if (lvl == 0) chk("out_data_gated", int'(outData), 0);
      else chk("out_data_head", int'(outData), int'(mq[0]));
      if (wrap_mon && int'(level) > max_lvl) max_lvl = int'(level);
      if (rxDataReq) req_cnt++;
      req_last = rxDataReq;
      if (outValid && outReady && !flush && lvl > 0) begin
        exp_b = mq.pop_front();
        chk("rd_data", int'(outData), int'(exp_b));
      end
    end
  end

  // UART stand-in: offers the head of tx_q, releases it after the pull pulse.
  initial forever begin : uart
    @(posedge ck);
    if (req_last && tx_q.size() > 0) void'(tx_q.pop_front());
    #1;
    if (tx_q.size() > 0) begin
      rxData      = tx_q[0];
      rxDataReady = 1'b1;
    end else begin
      rxData      = 8'($urandom);
      rxDataReady = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic wait_sent(input int budget, input string nm);
    int n = 0;
    while (tx_q.size() != 0 && n < budget) begin
      @(posedge ck);
      n++;
    end
    chk(nm, tx_q.size(), 0);
    #1;
  endtask

  task automatic wait_model_req(input string nm);
    int n = 0;
    while (!m_req && n < 20) begin
      step(1);
      n++;
    end
    chk(nm, int'(m_req), 1);
  endtask

  initial begin
    int rc0;
    // Reset state.
    step(3);
    chk("rst_req", int'(rxDataReq), 0);
    chk("rst_valid", int'(outValid), 0);
    chk("rst_data", int'(outData), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_stall", int'(rxDataStall), 0);
    arst = 1'b0;
    step(2);

    // Single byte.
    tx_q.push_back(8'hA5);
    wait_sent(20, "single_sent");
    step(3);
    chk("single_level", int'(level), 1);
    chk("single_data", int'(outData), 8'hA5);
    outReady = 1'b1;
    step(1);
    outReady = 1'b0;
    chk("single_drained", int'(outValid), 0);

    // Fill/stall with a 9th byte held.
    for (int i = 0; i < 9; i++) tx_q.push_back(8'(i));
    step(45);
    chk("fill_level", int'(level), 8);
    chk("fill_held", tx_q.size(), 1);
    rc0 = req_cnt;
    outReady = 1'b1;
    step(1);
    outReady = 1'b0;
    step(6);
    chk("fill_one_req", req_cnt - rc0, 1);
    outReady = 1'b1;
    step(15);
    outReady = 1'b0;

    // Wrap-around stream with consumer always ready.
    outReady = 1'b1;
    max_lvl  = 0;
    wrap_mon = 1'b1;
    for (int i = 16; i < 36; i++) tx_q.push_back(8'(i));
    wait_sent(100, "wrap_sent");
    step(4);
    wrap_mon = 1'b0;
    chk("wrap_max_level", int'(max_lvl <= 1), 1);
    outReady = 1'b0;

    // Simultaneous write and read at level 4.
    for (int i = 0; i < 4; i++) tx_q.push_back(8'(8'h40 + i));
    wait_sent(40, "simul_fill");
    step(3);
    chk("simul_pre_level", int'(level), 4);
    tx_q.push_back(8'h77);
    wait_model_req("simul_req");
    outReady = 1'b1;
    step(1);
    outReady = 1'b0;
    chk("simul_level", int'(level), 4);
    chk("simul_head", int'(outData), 8'h41);

    // Flush while REQ is out, level 3.
    outReady = 1'b1;
    step(1);
    outReady = 1'b0;
    tx_q.push_back(8'h99);
    wait_model_req("flush_req");
    chk("flush_pre_level", int'(level), 3);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_level", int'(level), 0);
    chk("flush_valid", int'(outValid), 0);
    step(5);
    chk("flush_no_store", int'(level), 0);

    // Async reset in GAP with level 5.
    for (int i = 0; i < 4; i++) tx_q.push_back(8'(8'h60 + i));
    wait_sent(40, "arst_fill");
    step(3);
    tx_q.push_back(8'h64);
    wait_model_req("arst_req");
    step(1);
    chk("arst_pre_level", int'(level), 5);
    #2;
    arst = 1'b1;
    #1;
    chk("arst_level", int'(level), 0);
    chk("arst_valid", int'(outValid), 0);
    chk("arst_data", int'(outData), 0);
    chk("arst_req_out", int'(rxDataReq), 0);
    chk("arst_stall", int'(rxDataStall), 0);
    step(2);
    arst = 1'b0;
    step(2);
    tx_q.push_back(8'h5A);
    wait_sent(20, "post_arst_sent");
    step(3);
    chk("post_arst_data", int'(outData), 8'h5A);
    outReady = 1'b1;
    step(2);

    // Randomized traffic: varying consumer pressure, occasional flush.
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if (i < 1500) outReady = ($urandom_range(0, 3) == 0);
      else          outReady = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 2) == 0 && tx_q.size() < 4) tx_q.push_back(8'($urandom));
    end
    flush    = 1'b0;
    outReady = 1'b1;
    wait_sent(200, "final_sent");
    step(10);
    chk("final_level", int'(level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
